// File: rtl/mc_controller.sv
// mc_controller
//   Control FSM for a multi-cycle RV32 subset datapath (lw/sw, R-type,
//   I-type ALU, jal, jalr, conditional branches, lui).
//   The instruction fields are captured when an instruction is fetched. All
//   outputs are decoded from the state and those captured fields. The branch
//   PC_update also uses the live ALU flags.
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_op/i_f3/i_f7        : live instruction fields from memory output
//   i_z, i_s              : ALU zero / sign flags
//   i_halt                : hold in FETCH while high
//   o_PC_update, o_Adr_src, o_mem_wr, o_reg_wr, o_IR_wr : datapath enables/selects
//   o_A_src, o_B_src, o_result_src, o_imm_src, o_ALU_op : datapath selects
//   o_instr_done          : high in the last state of every instruction
//   o_ill_op              : illegal opcode indication
//   o_state               : debug view of the FSM state
module mc_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_op,
    input  logic [2:0] i_f3,
    input  logic [6:0] i_f7,
    input  logic       i_z,
    input  logic       i_s,
    input  logic       i_halt,
    output logic       o_PC_update,
    output logic       o_Adr_src,
    output logic       o_mem_wr,
    output logic       o_reg_wr,
    output logic       o_IR_wr,
    output logic [1:0] o_A_src,
    output logic [1:0] o_B_src,
    output logic [1:0] o_result_src,
    output logic [2:0] o_imm_src,
    output logic [2:0] o_ALU_op,
    output logic       o_instr_done,
    output logic       o_ill_op,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_READ = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WRITE= 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_JAL      = 4'd9,
        S_JALR_ADR = 4'd10,
        S_JALR_PC  = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    state_t     r_state, w_next;
    logic [6:0] r_op;
    logic [2:0] r_f3;
    logic [6:0] r_f7;

    logic       w_PC_update, w_Adr_src, w_mem_wr, w_reg_wr, w_IR_wr;
    logic [1:0] w_A_src, w_B_src, w_result_src;
    logic [2:0] w_imm_src, w_ALU_op;
    logic       w_instr_done, w_ill_op, w_taken;
    logic       w_unused_f7;

    // Only f7[5] (add/sub select) matters to this decoder.
    assign w_unused_f7 = ^{r_f7[6], r_f7[4:0]};

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
            3'b111:  alu_dec = ALU_AND;
            3'b110:  alu_dec = ALU_OR;
            3'b100:  alu_dec = ALU_XOR;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_f3    <= '0;
            r_f7    <= '0;
        end else begin
            r_state <= w_next;
            // Capture alongside IR_wr so a halted FETCH leaves the fields untouched.
            if (w_IR_wr) begin
                r_op <= i_op;
                r_f3 <= i_f3;
                r_f7 <= i_f7;
            end
        end
    end

    always_comb begin
        case (r_f3)
            3'b000:  w_taken = i_z;
            3'b001:  w_taken = ~i_z;
            3'b100:  w_taken = i_s;
            3'b101:  w_taken = ~i_s;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_PC_update  = 1'b0;
        w_Adr_src    = 1'b0;
        w_mem_wr     = 1'b0;
        w_reg_wr     = 1'b0;
        w_IR_wr      = 1'b0;
        w_A_src      = 2'b00;
        w_B_src      = 2'b00;
        w_result_src = 2'b00;
        w_imm_src    = 3'b000;
        w_ALU_op     = ALU_ADD;
        w_instr_done = 1'b0;
        w_ill_op     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_B_src      = 2'b10;
                w_result_src = 2'b10;
                if (!i_halt) begin
                    w_IR_wr     = 1'b1;
                    w_PC_update = 1'b1;
                    w_next      = S_DECODE;
                end
            end
            S_DECODE: begin
                w_A_src   = 2'b01;
                w_B_src   = 2'b01;
                w_imm_src = (r_op == OP_JAL) ? 3'b011 : 3'b010;
                case (r_op)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR_ADR;
                    OP_BR:             w_next = S_BRANCH;
                    OP_LUI:            w_next = S_LUI;
                    default: begin
                        w_ill_op = 1'b1;
                        w_next   = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                w_A_src   = 2'b10;
                w_B_src   = 2'b01;
                w_imm_src = (r_op == OP_STORE) ? 3'b001 : 3'b000;
                w_next    = (r_op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_Adr_src = 1'b1;
                w_next    = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_result_src = 2'b01;
                w_reg_wr     = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_Adr_src    = 1'b1;
                w_mem_wr     = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_EXEC_R: begin
                w_A_src  = 2'b10;
                w_ALU_op = alu_dec(r_f3, r_f7[5]);
                w_next   = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_A_src  = 2'b10;
                w_B_src  = 2'b01;
                w_ALU_op = alu_dec(r_f3, 1'b0);
                w_next   = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_wr     = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JAL, S_JALR_PC: begin
                w_PC_update = 1'b1;
                w_A_src     = 2'b01;
                w_B_src     = 2'b10;
                w_next      = S_ALU_WB;
            end
            S_JALR_ADR: begin
                w_A_src = 2'b10;
                w_B_src = 2'b01;
                w_next  = S_JALR_PC;
            end
            S_BRANCH: begin
                w_A_src      = 2'b10;
                w_ALU_op     = ALU_SUB;
                w_PC_update  = w_taken;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_LUI: begin
                w_A_src   = 2'b11;
                w_B_src   = 2'b01;
                w_imm_src = 3'b100;
                w_next    = S_ALU_WB;
            end
            S_TRAP: begin
                w_ill_op = 1'b1;
                w_next   = S_TRAP;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset forces every output low combinationally, even though the
    // reset state (FETCH) would otherwise decode to active enables.
    assign o_PC_update  = rst_n & w_PC_update;
    assign o_Adr_src    = rst_n & w_Adr_src;
    assign o_mem_wr     = rst_n & w_mem_wr;
    assign o_reg_wr     = rst_n & w_reg_wr;
    assign o_IR_wr      = rst_n & w_IR_wr;
    assign o_A_src      = rst_n ? w_A_src      : '0;
    assign o_B_src      = rst_n ? w_B_src      : '0;
    assign o_result_src = rst_n ? w_result_src : '0;
    assign o_imm_src    = rst_n ? w_imm_src    : '0;
    assign o_ALU_op     = rst_n ? w_ALU_op     : '0;
    assign o_instr_done = rst_n & w_instr_done;
    assign o_ill_op     = rst_n & w_ill_op;
    assign o_state      = rst_n ? r_state      : '0;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
//   Bench for mc_controller. Each instruction is expanded into its expected
//   per-cycle output vectors from the instruction-level behaviour table below.
//   The vectors are then compared against the DUT every cycle, with randomised
//   halt, ALU flags and post-fetch field noise. A second instance is built with
//   ILLEGAL_TRAP=1 to cover the trap behaviour.
module tb_mc_controller;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] A_PC = 2'b00, A_OLD = 2'b01, A_AR = 2'b10, A_ZERO = 2'b11;
    localparam logic [1:0] B_BR = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
    localparam logic [1:0] R_ALUREG = 2'b00, R_MDR = 2'b01, R_ALU = 2'b10;
    localparam logic [2:0] I_I = 3'b000, I_S = 3'b001, I_B = 3'b010, I_J = 3'b011, I_U = 3'b100;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, SLTU = 3'b110;
    localparam logic L = 1'b0, H = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, i_z, i_s, i_halt;
    logic [6:0] i_op, i_f7;
    logic [2:0] i_f3;
    logic       o_PC_update, o_Adr_src, o_mem_wr, o_reg_wr, o_IR_wr, o_instr_done, o_ill_op;
    logic [1:0] o_A_src, o_B_src, o_result_src;
    logic [2:0] o_imm_src, o_ALU_op;
    logic [3:0] o_state;

    logic       t_rst_n;
    logic [6:0] t_op;
    logic       t_PC_update, t_Adr_src, t_mem_wr, t_reg_wr, t_IR_wr, t_instr_done, t_ill_op;
    logic [1:0] t_A_src, t_B_src, t_result_src;
    logic [2:0] t_imm_src, t_ALU_op;
    logic [3:0] t_state;

    mc_controller #(.ILLEGAL_TRAP(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_op(i_op), .i_f3(i_f3), .i_f7(i_f7),
        .i_z(i_z), .i_s(i_s), .i_halt(i_halt),
        .o_PC_update(o_PC_update), .o_Adr_src(o_Adr_src), .o_mem_wr(o_mem_wr),
        .o_reg_wr(o_reg_wr), .o_IR_wr(o_IR_wr), .o_A_src(o_A_src), .o_B_src(o_B_src),
        .o_result_src(o_result_src), .o_imm_src(o_imm_src), .o_ALU_op(o_ALU_op),
        .o_instr_done(o_instr_done), .o_ill_op(o_ill_op), .o_state(o_state)
    );

    mc_controller #(.ILLEGAL_TRAP(1'b1)) u_trap (
        .clk(clk), .rst_n(t_rst_n), .i_op(t_op), .i_f3(3'b000), .i_f7(7'b0000000),
        .i_z(1'b0), .i_s(1'b0), .i_halt(1'b0),
        .o_PC_update(t_PC_update), .o_Adr_src(t_Adr_src), .o_mem_wr(t_mem_wr),
        .o_reg_wr(t_reg_wr), .o_IR_wr(t_IR_wr), .o_A_src(t_A_src), .o_B_src(t_B_src),
        .o_result_src(t_result_src), .o_imm_src(t_imm_src), .o_ALU_op(t_ALU_op),
        .o_instr_done(t_instr_done), .o_ill_op(t_ill_op), .o_state(t_state)
    );

    // {PC_update, Adr_src, mem_wr, reg_wr, IR_wr, A_src, B_src, result_src, imm_src, ALU_op, instr_done, ill_op}
    logic [18:0] w_obs, w_tobs;
    assign w_obs  = {o_PC_update, o_Adr_src, o_mem_wr, o_reg_wr, o_IR_wr, o_A_src, o_B_src,
                     o_result_src, o_imm_src, o_ALU_op, o_instr_done, o_ill_op};
    assign w_tobs = {t_PC_update, t_Adr_src, t_mem_wr, t_reg_wr, t_IR_wr, t_A_src, t_B_src,
                     t_result_src, t_imm_src, t_ALU_op, t_instr_done, t_ill_op};

    int n_assert = 0;
    int n_fail   = 0;

    logic [18:0] exp_q[$];
    bit          br_q[$];
    string       tag_q[$];
    logic [6:0]  legal_ops[8] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_BR, OP_LUI};

    function automatic logic [18:0] pk(input logic pc, input logic adr, input logic mw,
                                       input logic rw, input logic ir, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [2:0] imm, input logic [2:0] alu,
                                       input logic done, input logic ill);
        pk = {pc, adr, mw, rw, ir, a, b, res, imm, alu, done, ill};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        is_legal = 1'b0;
        foreach (legal_ops[j]) if (legal_ops[j] == op) is_legal = 1'b1;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_of = sub ? SUB : ADD;
            3'b111:  alu_of = AND_;
            3'b110:  alu_of = OR_;
            3'b100:  alu_of = XOR_;
            3'b010:  alu_of = SLT;
            3'b011:  alu_of = SLTU;
            default: alu_of = ADD;
        endcase
    endfunction

    // beq/bne compare on zero, blt/bge on sign, other f3 never branch
    function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic s);
        taken_of = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z :
                   (f3 == 3'b100) ? s : (f3 == 3'b101) ? !s : 1'b0;
    endfunction

    function automatic void step(input logic [18:0] v, input bit br, input string tag);
        exp_q.push_back(v);
        br_q.push_back(br);
        tag_q.push_back(tag);
    endfunction

    // Expected cycles after FETCH for one instruction.
    function automatic void plan(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [18:0] wb, link;
        wb   = pk(L, L, L, H, L, A_PC, B_BR, R_ALUREG, I_I, ADD, H, L);
        link = pk(H, L, L, L, L, A_OLD, B_FOUR, R_ALUREG, I_I, ADD, L, L);
        exp_q.delete(); br_q.delete(); tag_q.delete();
        step(pk(L, L, L, L, L, A_OLD, B_IMM, R_ALUREG, (op == OP_JAL) ? I_J : I_B, ADD, L,
                is_legal(op) ? L : H), 1'b0, "decode");
        case (op)
            OP_LOAD: begin
                step(pk(L, L, L, L, L, A_AR, B_IMM, R_ALUREG, I_I, ADD, L, L), 1'b0, "lw_adr");
                step(pk(L, H, L, L, L, A_PC, B_BR, R_ALUREG, I_I, ADD, L, L), 1'b0, "lw_read");
                step(pk(L, L, L, H, L, A_PC, B_BR, R_MDR, I_I, ADD, H, L), 1'b0, "lw_wb");
            end
            OP_STORE: begin
                step(pk(L, L, L, L, L, A_AR, B_IMM, R_ALUREG, I_S, ADD, L, L), 1'b0, "sw_adr");
                step(pk(L, H, H, L, L, A_PC, B_BR, R_ALUREG, I_I, ADD, H, L), 1'b0, "sw_write");
            end
            OP_R: begin
                step(pk(L, L, L, L, L, A_AR, B_BR, R_ALUREG, I_I, alu_of(f3, f7[5]), L, L), 1'b0, "exec_r");
                step(wb, 1'b0, "r_wb");
            end
            OP_I: begin
                step(pk(L, L, L, L, L, A_AR, B_IMM, R_ALUREG, I_I, alu_of(f3, 1'b0), L, L), 1'b0, "exec_i");
                step(wb, 1'b0, "i_wb");
            end
            OP_JAL: begin
                step(link, 1'b0, "jal");
                step(wb, 1'b0, "jal_wb");
            end
            OP_JALR: begin
                step(pk(L, L, L, L, L, A_AR, B_IMM, R_ALUREG, I_I, ADD, L, L), 1'b0, "jalr_adr");
                step(link, 1'b0, "jalr_pc");
                step(wb, 1'b0, "jalr_wb");
            end
            OP_BR:  step(pk(L, L, L, L, L, A_AR, B_BR, R_ALUREG, I_I, SUB, H, L), 1'b1, "branch");
            OP_LUI: begin
                step(pk(L, L, L, L, L, A_ZERO, B_IMM, R_ALUREG, I_U, ADD, L, L), 1'b0, "lui");
                step(wb, 1'b0, "lui_wb");
            end
            default: ;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_zs(input int zs);
        if (zs < 0) {i_z, i_s} = 2'($urandom);
        else        {i_z, i_s} = 2'(zs);
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int pre_halt, input bit post_halt, input int zs, input int abort_at);
        logic [18:0] exp;
        plan(op, f3, f7);
        i_op = op; i_f3 = f3; i_f7 = f7;
        for (int c = 0; c <= pre_halt; c++) begin
            i_halt = (c < pre_halt);
            drive_zs(zs);
            @(negedge clk);
            if (i_halt) chk("fetch_halt", {4'b0, w_obs}, {4'b0, pk(L, L, L, L, L, A_PC, B_FOUR, R_ALU, I_I, ADD, L, L)});
            else        chk("fetch",      {4'b0, w_obs}, {4'b0, pk(H, L, L, L, H, A_PC, B_FOUR, R_ALU, I_I, ADD, L, L)});
            @(posedge clk); #1;
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            i_op   = 7'($urandom);
            i_f3   = 3'($urandom);
            i_f7   = 7'($urandom);
            i_halt = post_halt ? 1'b1 : 1'($urandom);
            drive_zs(zs);
            @(negedge clk);
            exp = exp_q[k];
            if (br_q[k]) exp[18] = taken_of(f3, i_z, i_s);
            chk(tag_q[k], {4'b0, w_obs}, {4'b0, exp});
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk("abort_reset", {o_state, w_obs}, 23'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; t_rst_n = 1'b0; t_op = '0;
        i_op = '0; i_f3 = '0; i_f7 = '0; i_z = 1'b0; i_s = 1'b0; i_halt = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_main", {o_state, w_obs}, 23'd0);
        chk("reset_trap", {t_state, w_tobs}, 23'd0);

        // Trapping variant: illegal opcode locks up until reset.
        @(posedge clk); #1;
        t_rst_n = 1'b1; t_op = 7'b1111111;
        @(negedge clk);
        chk("trap_fetch", {4'b0, w_tobs}, {4'b0, pk(H, L, L, L, H, A_PC, B_FOUR, R_ALU, I_I, ADD, L, L)});
        @(posedge clk); #1;
        t_op = OP_R;
        @(negedge clk);
        chk("trap_decode", {4'b0, w_tobs}, {4'b0, pk(L, L, L, L, L, A_OLD, B_IMM, R_ALUREG, I_B, ADD, L, H)});
        repeat (4) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("trap_hold", {4'b0, w_tobs}, {4'b0, pk(L, L, L, L, L, A_PC, B_BR, R_ALUREG, I_I, ADD, L, H)});
        end
        #2 t_rst_n = 1'b0;
        #1 chk("trap_reset", {t_state, w_tobs}, 23'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(OP_R,     3'b000, 7'b0000000, 0, 1'b0, -1, -1);  // add
        run_instr(OP_R,     3'b000, 7'b0100000, 0, 1'b0, -1, -1);  // sub
        run_instr(OP_LOAD,  3'b010, 7'b0000000, 0, 1'b0, -1, -1);  // lw
        run_instr(OP_STORE, 3'b010, 7'b0000000, 0, 1'b0, -1, -1);  // sw
        run_instr(OP_BR,    3'b000, 7'b0000000, 0, 1'b0,  2, -1);  // beq z=1
        run_instr(OP_BR,    3'b000, 7'b0000000, 0, 1'b0,  1, -1);  // beq z=0
        run_instr(OP_BR,    3'b100, 7'b0000000, 0, 1'b0,  1, -1);  // blt s=1
        run_instr(OP_BR,    3'b101, 7'b0000000, 0, 1'b0,  1, -1);  // bge s=1
        run_instr(OP_I,     3'b000, 7'b0100000, 0, 1'b0, -1, -1);  // addi ignores f7
        run_instr(OP_JAL,   3'b000, 7'b0000000, 0, 1'b0, -1, -1);
        run_instr(OP_JALR,  3'b000, 7'b0000000, 0, 1'b0, -1, -1);
        run_instr(OP_LUI,   3'b000, 7'b0000000, 0, 1'b0, -1, -1);
        run_instr(7'b1111111, 3'b000, 7'b0000000, 0, 1'b0, -1, -1);  // illegal, refetch
        run_instr(OP_R,     3'b111, 7'b0000000, 0, 1'b1, -1, -1);  // halt during execution
        run_instr(OP_R,     3'b110, 7'b0000000, 3, 1'b0, -1, -1);  // then held in FETCH
        run_instr(OP_STORE, 3'b010, 7'b0000000, 0, 1'b0, -1,  2);  // reset during MEM_WRITE
        run_instr(OP_R,     3'b100, 7'b0000000, 0, 1'b0, -1, -1);

        for (int n = 0; n < 250; n++) begin
            int         sel;
            int         pre;
            int         ab;
            logic [6:0] rop;
            sel = int'($urandom % 10);
            if (sel < 8) rop = legal_ops[sel];
            else if (sel == 8) rop = OP_BR;
            else begin
                rop = 7'($urandom);
                while (is_legal(rop)) rop = 7'($urandom);
            end
            pre = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
            ab  = ($urandom % 12 == 0) ? int'($urandom % 3) : -1;
            run_instr(rop, 3'($urandom), 7'($urandom), pre, 1'($urandom % 8 == 0), -1, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 0: 0 = illegal opcode pulses ill_op and refetches; 1 = enter TRAP until reset.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have inputs op 7, f3 3, f7 7 (live instruction fields from memory output) and z 1, s 1 (ALU zero, ALU sign).
REQ-005 SHALL have input halt  1  hold in FETCH when high.
REQ-006 SHALL have outputs PC_update, Adr_src, mem_wr, reg_wr, IR_wr (1 each); A_src, B_src, result_src (2 each); imm_src, ALU_op (3 each).
REQ-007 SHALL have outputs instr_done 1 (retire pulse), ill_op 1 (illegal pulse), state 4 (debug).

Function
REQ-008 Encodings SHALL be: A_src 00 PC/01 oldPC/10 AR/11 zero; B_src 00 BR/01 imm/10 four; result_src 00 ALUreg/01 MDR/10 ALU; Adr_src 0 PC/1 result; imm_src 000 I/001 S/010 B/011 J/100 U; ALU_op 000 ADD/001 SUB/010 AND/011 OR/100 XOR/101 SLT/110 SLTU.
REQ-009 Outputs SHALL be Moore decodes of state plus captured fields; unlisted outputs in a state SHALL be 0.
REQ-010 FETCH SHALL drive Adr_src 0, IR_wr 1, A_src 00, B_src 10, ADD, result_src 10, PC_update 1; on that edge op/f3/f7 SHALL be captured into internal registers used by all later states.
REQ-011 FETCH with halt=1 SHALL drive all write enables 0 and remain in FETCH; halt SHALL be ignored in all other states.
REQ-012 DECODE SHALL drive A_src 01, B_src 01, ADD, imm_src J if captured op=1101111 else B.
REQ-013 DECODE transitions SHALL be: 0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1101111 -> JAL; 1100111 -> JALR_ADR; 1100011 -> BRANCH; 0110111 -> LUI; other -> FETCH (ILLEGAL_TRAP=0) or TRAP.
REQ-014 MEM_ADR: A_src 10, B_src 01, ADD, imm_src I (load) or S (store); -> MEM_READ or MEM_WRITE.
REQ-015 MEM_READ: Adr_src 1, result_src 00 -> MEM_WB; MEM_WB: result_src 01, reg_wr 1 -> FETCH.
REQ-016 MEM_WRITE: Adr_src 1, result_src 00, mem_wr 1 -> FETCH.
REQ-017 EXEC_R: A_src 10, B_src 00; ALU_op from f3/f7: 000 ADD (f7[5]=0) or SUB (f7[5]=1), 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU; -> ALU_WB.
REQ-018 EXEC_I: A_src 10, B_src 01, imm_src I; same f3 map, f3=000 always ADD; -> ALU_WB.
REQ-019 ALU_WB: result_src 00, reg_wr 1 -> FETCH.
REQ-020 JAL: PC_update 1, result_src 00, A_src 01, B_src 10, ADD -> ALU_WB.
REQ-021 JALR_ADR: A_src 10, B_src 01, imm_src I, ADD -> JALR_PC; JALR_PC: as JAL -> ALU_WB.
REQ-022 BRANCH: A_src 10, B_src 00, SUB, result_src 00, PC_update = z (f3 000), !z (001), s (100), !s (101), 0 otherwise; -> FETCH.
REQ-023 LUI: A_src 11, B_src 01, imm_src U, ADD -> ALU_WB.
REQ-024 Latency SHALL be: branch 3; sw, R, I, LUI, JAL 4; lw, JALR 5 cycles.
REQ-025 instr_done SHALL be 1 exactly in the last state of each instruction; ill_op SHALL be 1 for the DECODE cycle with illegal op.
REQ-026 TRAP SHALL drive all enables 0 and ill_op 1, held until reset.

Reset
REQ-027 rst_n low SHALL immediately force state FETCH, captured fields 0, and all outputs 0 regardless of clk.
REQ-028 rst_n low mid-instruction SHALL abort it with no partial write after assertion; first FETCH executes on first rising edge after deassertion.

Verification
REQ-029 add x3,x1,x2 (op 0110011, f3 000, f7 0) -> FETCH,DECODE,EXEC_R(ALU_op 000),ALU_WB(reg_wr 1); instr_done on cycle 4.
REQ-030 lw (0000011) -> 5 states, MEM_ADR imm_src 000, MEM_WB result_src 01 reg_wr 1; sw (0100011) -> mem_wr 1 in cycle 4 only.
REQ-031 beq with z=1 -> PC_update 1 in cycle 3; z=0 -> 0; blt with s=1 -> 1; bge with s=1 -> 0.
REQ-032 op 1111111, ILLEGAL_TRAP=0 -> ill_op pulse, back to FETCH, no writes; ILLEGAL_TRAP=1 -> TRAP held until rst_n low.
REQ-033 halt=1 asserted during EXEC_R -> instruction completes, next FETCH holds with IR_wr 0, PC_update 0 until halt=0.
REQ-034 rst_n low during MEM_WRITE -> mem_wr drops to 0 asynchronously, state reads FETCH.
